pcie_tl_fc_credit_ctrl: RTL and testbench

//  Transmit-side flow-control credit manager for the PCIe transaction layer. Tracks per-VC,
//  per-type (P/NP/CPL) header and data credits advertised by the link partner. Gates the TX
//  VC arbiter: a VC may be serviced only when its head TLP fits the remaining credit.

---
 rtl/pcie_tl_pkg.sv | 32 +++
 rtl/pcie_fc_credit_cnt.sv | 94 +++++++++
 rtl/pcie_tl_fc_credit_ctrl.sv | 152 +++++++++++++++
 tb/tb_pcie_tl_fc_credit_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tl_pkg.sv
// PCIe TL flow-control shared types and helpers.
// Credit type/state encodings and the payload credit cost function.
package pcie_tl_pkg;

  localparam int FC_HDR_W  = 8;
  localparam int FC_DATA_W = 12;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_e;

  typedef enum logic [1:0] {
    FC_RESET  = 2'd0,
    FC_INIT   = 2'd1,
    FC_ACTIVE = 2'd2
  } fc_state_e;

  // One data credit is 4 DW; a length of 0 encodes 1024 DW.
  function automatic logic [8:0] fc_data_cost(
    input logic       has_data,
    input logic [9:0] len
  );
    logic [10:0] s;
    s = {1'b0, len} + 11'd3;
    if (!has_data) return 9'd0;
    if (len == 10'd0) return 9'd256;
    return s[10:2];
  endfunction

endpackage

// File: rtl/pcie_fc_credit_cnt.sv
// Header and data credit tracking for one FC type of one VC.
// Holds limit/consumed pairs, infinite flags and the modular gate.
module pcie_fc_credit_cnt
  import pcie_tl_pkg::*;
#(
  parameter int HDR_W  = FC_HDR_W,
  parameter int DATA_W = FC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              init_i,
  input  logic              upd_i,
  input  logic [HDR_W-1:0]  hdr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [8:0]        data_cost_i,
  input  logic              debit_i,
  output logic              ok_o
);

  localparam logic [HDR_W-1:0] H_HALF =
    HDR_W'(1) << (HDR_W - 1);
  localparam logic [DATA_W-1:0] D_HALF =
    DATA_W'(1) << (DATA_W - 1);

  logic [HDR_W-1:0]  hdr_lim_q, hdr_lim_d;
  logic [HDR_W-1:0]  hdr_cons_q, hdr_cons_d;
  logic              hdr_inf_q, hdr_inf_d;
  logic [DATA_W-1:0] data_lim_q, data_lim_d;
  logic [DATA_W-1:0] data_cons_q, data_cons_d;
  logic              data_inf_q, data_inf_d;

  logic [HDR_W-1:0]  hdr_room;
  logic [DATA_W-1:0] data_room;
  logic [DATA_W-1:0] data_cost;

  assign data_cost = DATA_W'(data_cost_i);
  assign hdr_room  = hdr_lim_q - hdr_cons_q - HDR_W'(1);
  assign data_room = data_lim_q - data_cons_q - data_cost;

  // Room must land in the lower half of the modular window.
  assign ok_o = (hdr_inf_q || hdr_room <= H_HALF) &&
                (data_inf_q || data_room <= D_HALF);

  always_comb begin
    hdr_lim_d   = hdr_lim_q;
    hdr_cons_d  = hdr_cons_q;
    hdr_inf_d   = hdr_inf_q;
    data_lim_d  = data_lim_q;
    data_cons_d = data_cons_q;
    data_inf_d  = data_inf_q;
    if (clr_i) begin
      hdr_lim_d   = '0;
      hdr_cons_d  = '0;
      hdr_inf_d   = 1'b0;
      data_lim_d  = '0;
      data_cons_d = '0;
      data_inf_d  = 1'b0;
    end else begin
      if (init_i) begin
        hdr_lim_d  = hdr_i;
        hdr_inf_d  = (hdr_i == '0);
        data_lim_d = data_i;
        data_inf_d = (data_i == '0);
      end else if (upd_i) begin
        if (!hdr_inf_q)  hdr_lim_d  = hdr_i;
        if (!data_inf_q) data_lim_d = data_i;
      end
      if (debit_i) begin
        hdr_cons_d  = hdr_cons_q + HDR_W'(1);
        data_cons_d = data_cons_q + data_cost;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_lim_q   <= '0;
      hdr_cons_q  <= '0;
      hdr_inf_q   <= 1'b0;
      data_lim_q  <= '0;
      data_cons_q <= '0;
      data_inf_q  <= 1'b0;
    end else begin
      hdr_lim_q   <= hdr_lim_d;
      hdr_cons_q  <= hdr_cons_d;
      hdr_inf_q   <= hdr_inf_d;
      data_lim_q  <= data_lim_d;
      data_cons_q <= data_cons_d;
      data_inf_q  <= data_inf_d;
    end
  end

endmodule

// File: rtl/pcie_tl_fc_credit_ctrl.sv
// TX flow-control credit manager: per-VC FC init FSM,
// credit gating of head TLPs and debit/replenish routing.
module pcie_tl_fc_credit_ctrl
  import pcie_tl_pkg::*;
#(
  parameter int NUM_VC = 2,
  parameter int HDR_W  = FC_HDR_W,
  parameter int DATA_W = FC_DATA_W,
  localparam int VCW   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 link_up_i,
  input  logic [2*NUM_VC-1:0]  head_type_i,
  input  logic [NUM_VC-1:0]    head_has_data_i,
  input  logic [10*NUM_VC-1:0] head_len_i,
  output logic [NUM_VC-1:0]    fc_ok_o,
  input  logic                 tlp_sent_i,
  input  logic [VCW-1:0]       tlp_sent_vc_i,
  input  logic                 fc_upd_valid_i,
  input  logic                 fc_upd_init_i,
  input  logic [VCW-1:0]       fc_upd_vc_i,
  input  logic [1:0]           fc_upd_type_i,
  input  logic [HDR_W-1:0]     fc_upd_hdr_i,
  input  logic [DATA_W-1:0]    fc_upd_data_i,
  output logic [NUM_VC-1:0]    fc_active_o,
  output logic                 fc_err_o
);

  fc_state_e   state_q [NUM_VC];
  fc_state_e   state_d [NUM_VC];
  logic [2:0]  seen_q  [NUM_VC];
  logic [2:0]  seen_d  [NUM_VC];
  logic        err_q, err_d;

  logic [1:0]  hd_type [NUM_VC];
  logic [8:0]  cost    [NUM_VC];
  logic [NUM_VC-1:0]   upd_hit;
  logic [NUM_VC-1:0]   clr;
  logic [NUM_VC-1:0]   ok;
  logic [3*NUM_VC-1:0] cnt_ok;
  logic [3*NUM_VC-1:0] cnt_init;
  logic [3*NUM_VC-1:0] cnt_upd;
  logic [3*NUM_VC-1:0] cnt_dbt;
  logic                upd_rsvd;
  logic                sent_ok;

  assign upd_rsvd = (fc_upd_type_i == 2'd3);

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      hd_type[v] = head_type_i[2*v +: 2];
      cost[v]    = fc_data_cost(head_has_data_i[v],
                                head_len_i[10*v +: 10]);
      upd_hit[v] = fc_upd_valid_i && !upd_rsvd &&
                   (fc_upd_vc_i == VCW'(v));
      clr[v]     = !link_up_i || (state_q[v] == FC_RESET);
      fc_active_o[v] = (state_q[v] == FC_ACTIVE);
      unique case (hd_type[v])
        2'd0:    ok[v] = cnt_ok[3*v];
        2'd1:    ok[v] = cnt_ok[3*v+1];
        2'd2:    ok[v] = cnt_ok[3*v+2];
        default: ok[v] = 1'b0;
      endcase
      fc_ok_o[v] = ok[v] && fc_active_o[v];
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    for (genvar t = 0; t < 3; t++) begin : g_ty
      localparam int I = 3 * v + t;
      logic ty_hit;
      assign ty_hit = (fc_upd_type_i == 2'(t));
      assign cnt_init[I] = upd_hit[v] && fc_upd_init_i &&
                           ty_hit && (state_q[v] == FC_INIT);
      assign cnt_upd[I]  = upd_hit[v] && !fc_upd_init_i &&
                           ty_hit && (state_q[v] == FC_ACTIVE);
      assign cnt_dbt[I]  = tlp_sent_i &&
                           (tlp_sent_vc_i == VCW'(v)) &&
                           (hd_type[v] == 2'(t));
      pcie_fc_credit_cnt #(
        .HDR_W  (HDR_W),
        .DATA_W (DATA_W)
      ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr[v]),
        .init_i      (cnt_init[I]),
        .upd_i       (cnt_upd[I]),
        .hdr_i       (fc_upd_hdr_i),
        .data_i      (fc_upd_data_i),
        .data_cost_i (cost[v]),
        .debit_i     (cnt_dbt[I]),
        .ok_o        (cnt_ok[I])
      );
    end
  end

  always_comb begin
    sent_ok = 1'b0;
    for (int v = 0; v < NUM_VC; v++)
      if (tlp_sent_vc_i == VCW'(v)) sent_ok = fc_ok_o[v];
    err_d = err_q ||
            (tlp_sent_i && !sent_ok) ||
            (fc_upd_valid_i && upd_rsvd);
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      state_d[v] = state_q[v];
      seen_d[v]  = seen_q[v];
      if (!link_up_i) begin
        state_d[v] = FC_RESET;
        seen_d[v]  = 3'b000;
      end else begin
        unique case (state_q[v])
          FC_RESET: begin
            state_d[v] = FC_INIT;
            seen_d[v]  = 3'b000;
          end
          FC_INIT: begin
            if (upd_hit[v] && fc_upd_init_i)
              seen_d[v] = seen_q[v] |
                          (3'b001 << fc_upd_type_i);
            if (&seen_d[v]) state_d[v] = FC_ACTIVE;
          end
          FC_ACTIVE: state_d[v] = FC_ACTIVE;
          default:   state_d[v] = FC_RESET;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= FC_RESET;
        seen_q[v]  <= 3'b000;
      end
    end else begin
      err_q <= err_d;
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= state_d[v];
        seen_q[v]  <= seen_d[v];
      end
    end
  end

  assign fc_err_o = err_q;

endmodule

// File: tb/tb_pcie_tl_fc_credit_ctrl.sv
// Directed bench for the FC credit manager; expectations are
// queued by the stimulus and checked by a negedge monitor.
module tb_pcie_tl_fc_credit_ctrl;

  logic        clk;
  logic        rst_n;
  logic        link_up;
  logic [3:0]  head_type;
  logic [1:0]  head_has_data;
  logic [19:0] head_len;
  logic [1:0]  fc_ok;
  logic        tlp_sent;
  logic [0:0]  tlp_sent_vc;
  logic        upd_valid;
  logic        upd_init;
  logic [0:0]  upd_vc;
  logic [1:0]  upd_type;
  logic [7:0]  upd_hdr;
  logic [11:0] upd_data;
  logic [1:0]  fc_active;
  logic        fc_err;

  typedef struct {
    string      name;
    logic [1:0] ok;
    logic [1:0] act;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pcie_tl_fc_credit_ctrl #(
    .NUM_VC (2),
    .HDR_W  (8),
    .DATA_W (12)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .link_up_i       (link_up),
    .head_type_i     (head_type),
    .head_has_data_i (head_has_data),
    .head_len_i      (head_len),
    .fc_ok_o         (fc_ok),
    .tlp_sent_i      (tlp_sent),
    .tlp_sent_vc_i   (tlp_sent_vc),
    .fc_upd_valid_i  (upd_valid),
    .fc_upd_init_i   (upd_init),
    .fc_upd_vc_i     (upd_vc),
    .fc_upd_type_i   (upd_type),
    .fc_upd_hdr_i    (upd_hdr),
    .fc_upd_data_i   (upd_data),
    .fc_active_o     (fc_active),
    .fc_err_o        (fc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (fc_ok !== e.ok || fc_active !== e.act ||
          fc_err !== e.err) begin
        n_fail++;
        $display("FAIL %s: ok=%b act=%b err=%b, want ok=%b act=%b err=%b",
                 e.name, fc_ok, fc_active, fc_err,
                 e.ok, e.act, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tlp_sent  = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic expect_s(input string n, input logic [1:0] o,
                          input logic [1:0] a, input logic e);
    exp_t x;
    x.name = n;
    x.ok   = o;
    x.act  = a;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic send();
    tlp_sent    = 1'b1;
    tlp_sent_vc = 1'b0;
  endtask

  task automatic dllp(input logic i, input logic [1:0] t,
                      input logic [7:0] h, input logic [11:0] d);
    upd_valid = 1'b1;
    upd_init  = i;
    upd_vc    = 1'b0;
    upd_type  = t;
    upd_hdr   = h;
    upd_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    rst_n = 1'b0; link_up = 1'b0;
    head_type = 4'd0; head_has_data = 2'b00; head_len = 20'd1;
    tlp_sent = 1'b0; tlp_sent_vc = 1'b0;
    upd_valid = 1'b0; upd_init = 1'b0; upd_vc = 1'b0;
    upd_type = 2'd0; upd_hdr = 8'd0; upd_data = 12'd0;
    expect_s("reset", 2'b00, 2'b00, 1'b0);
    tick(); tick();
    rst_n = 1'b1; link_up = 1'b1;

    // FC init of VC0
    tick(); dllp(1'b1, 2'd0, 8'd4, 12'd16);
    expect_s("init_p", 2'b00, 2'b00, 1'b0);
    tick(); dllp(1'b1, 2'd1, 8'd2, 12'd0);
    expect_s("init_np", 2'b00, 2'b00, 1'b0);
    tick(); dllp(1'b1, 2'd2, 8'd0, 12'd0);
    expect_s("init_cpl", 2'b00, 2'b00, 1'b0);
    tick(); expect_s("active", 2'b01, 2'b01, 1'b0);

    // header limit 2, back-to-back sends
    dllp(1'b0, 2'd0, 8'd2, 12'd16);
    tick(); send(); expect_s("bb1", 2'b01, 2'b01, 1'b0);
    tick(); send(); expect_s("bb2", 2'b01, 2'b01, 1'b0);
    tick(); dllp(1'b0, 2'd0, 8'd3, 12'd16);
    expect_s("bb3_block", 2'b00, 2'b01, 1'b0);
    tick(); expect_s("upd3", 2'b01, 2'b01, 1'b0);

    // data limit 8 credits
    head_has_data = 2'b01; head_len = 20'd33;
    dllp(1'b0, 2'd0, 8'd100, 12'd8);
    tick(); expect_s("len33", 2'b00, 2'b01, 1'b0);
    tick(); head_len = 20'd32;
    expect_s("len32", 2'b01, 2'b01, 1'b0);
    tick(); head_len = 20'd0;
    expect_s("len0", 2'b00, 2'b01, 1'b0);
    dllp(1'b0, 2'd0, 8'd100, 12'd256);
    tick(); expect_s("len0_fit", 2'b01, 2'b01, 1'b0);
    head_has_data = 2'b00; head_len = 20'd1;

    // walk hdr CONSUMED from 2 to 254, limit one ahead
    dllp(1'b0, 2'd0, 8'd3, 12'd256);
    c = 8'd2;
    for (int i = 0; i < 252; i++) begin
      tick(); send();
      dllp(1'b0, 2'd0, c + 8'd2, 12'd256);
      c = c + 8'd1;
    end
    tick(); dllp(1'b0, 2'd0, 8'd1, 12'd256);
    expect_s("pre_wrap", 2'b01, 2'b01, 1'b0);
    tick(); send(); expect_s("wrap_fit", 2'b01, 2'b01, 1'b0);
    tick(); send(); expect_s("wrap_255", 2'b01, 2'b01, 1'b0);
    tick(); send(); expect_s("wrap_zero", 2'b01, 2'b01, 1'b0);
    tick(); expect_s("wrap_block", 2'b00, 2'b01, 1'b0);

    // send without credit, then same-cycle send + update
    send(); tick(); expect_s("err_set", 2'b00, 2'b01, 1'b1);
    send(); dllp(1'b0, 2'd0, 8'd132, 12'd256);
    tick(); expect_s("same_cyc", 2'b01, 2'b01, 1'b1);
    tick(); head_type = 4'd3;
    expect_s("rsvd_head", 2'b00, 2'b01, 1'b1);

    // link drop mid-traffic and re-init
    tick(); head_type = 4'd0; link_up = 1'b0; send();
    expect_s("drop_cyc", 2'b01, 2'b01, 1'b1);
    tick(); expect_s("link_down", 2'b00, 2'b00, 1'b1);
    link_up = 1'b1;
    tick(); dllp(1'b1, 2'd0, 8'd10, 12'd0);
    expect_s("reinit", 2'b00, 2'b00, 1'b1);
    tick(); dllp(1'b1, 2'd1, 8'd2, 12'd0);
    tick(); dllp(1'b1, 2'd2, 8'd0, 12'd0);
    tick(); expect_s("reactive", 2'b01, 2'b01, 1'b1);

    // async reset mid-burst
    tick(); send(); #2 rst_n = 1'b0;
    expect_s("async_rst", 2'b00, 2'b00, 1'b0);
    tick(); tick();
    rst_n = 1'b1; link_up = 1'b0;
    tick(); dllp(1'b0, 2'd3, 8'd5, 12'd5);
    expect_s("rsvd_pre", 2'b00, 2'b00, 1'b0);
    tick(); expect_s("rsvd_dllp", 2'b00, 2'b00, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
